wb_downsizer: RTL and testbench

Parametrised Wishbone (classic) width bridge that splits one wide-bus transfer into a locked sequence of narrow-bus beats. It is the next generation of our fixed-ratio write-only adapter: it supports any power-of-two ratio, reads as well as writes, and skips byte lanes that are not selected. It also bounds retries and handles errors and aborts. It sits between the 128-bit main bus and narrow peripherals such as the VGA text buffer, UART, keyboard and future SPI flash.

---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_beat_select.sv | 29 ++
 rtl/wb_downsizer.sv | 177 +++++++++++++++++
 tb/tb_wb_downsizer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions.
//   wb_dsz_state_t : wb_downsizer FSM state, also exported on its debug port
//   wb_term_t      : upstream termination code (ACK/ERR/RTY), shared with wb_mux_n
//   wb_lane_ratio  : log2 of the wide/narrow width ratio, used to size beat indices
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2,
    ST_RESP  = 2'd3
  } wb_dsz_state_t;

  typedef enum logic [1:0] {
    TERM_ACK = 2'd0,
    TERM_ERR = 2'd1,
    TERM_RTY = 2'd2
  } wb_term_t;

  function automatic int wb_lane_ratio(input int wide_w, input int narrow_w);
    return $clog2(wide_w / narrow_w);
  endfunction

endpackage

// File: rtl/wb_beat_select.sv
// Priority encoder over the per-beat byte-select slices.
//   sel       : full wide byte-select vector (RATIO*NS bits)
//   start     : first beat index to consider (may equal RATIO, meaning "none")
//   idx       : lowest beat >= start whose sel slice is nonzero
//   none_left : no such beat exists (idx is then 0)
module wb_beat_select #(
  parameter int RATIO = 16,
  parameter int NS    = 1,
  parameter int KW    = 4
) (
  input  logic [RATIO*NS-1:0] sel,
  input  logic [KW:0]         start,
  output logic [KW-1:0]       idx,
  output logic                none_left
);

  // Scan high to low so the last hit written is the lowest qualifying beat.
  always_comb begin
    idx       = '0;
    none_left = 1'b1;
    for (int i = RATIO - 1; i >= 0; i--) begin
      if ((i >= int'(start)) && (|sel[i*NS +: NS])) begin
        idx       = KW'(i);
        none_left = 1'b0;
      end
    end
  end

endmodule

// File: rtl/wb_downsizer.sv
// Wishbone classic width bridge: one wide transfer becomes a locked burst of
// narrow beats, skipping beats whose byte selects are all zero.
//   clk48, rst_n              : clock, async active-low reset
//   wbm_* (wide, upstream)    : adr/dat/sel/we/stb/cyc in; dat/ack/err/rty out
//   wbs_* (narrow, downstream): adr/dat/sel/we/stb/cyc out; dat/ack/err/rty in
//   dbg_state                 : current FSM state
//
// Handshake: a request is accepted when cyc & stb are seen in IDLE. The
// narrow slave terminates a beat by asserting exactly one of ack/err/rty
// while stb is high (err wins over rty, rty over ack). Upstream sees a single
// one-cycle ack/err/rty pulse per request, unless the master drops cyc first,
// which aborts the burst silently. All outputs decode registered state only.
module wb_downsizer
  import wb_pkg::*;
#(
  parameter int WIDE_W    = 128,
  parameter int NARROW_W  = 8,
  parameter int ADDR_W    = 14,
  parameter int MAX_RETRY = 3
) (
  input  logic                  clk48,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     wbm_adr_i,
  input  logic [WIDE_W-1:0]     wbm_dat_i,
  output logic [WIDE_W-1:0]     wbm_dat_o,
  input  logic [WIDE_W/8-1:0]   wbm_sel_i,
  input  logic                  wbm_we_i,
  input  logic                  wbm_stb_i,
  input  logic                  wbm_cyc_i,
  output logic                  wbm_ack_o,
  output logic                  wbm_err_o,
  output logic                  wbm_rty_o,
  output logic [ADDR_W-1:0]     wbs_adr_o,
  output logic [NARROW_W-1:0]   wbs_dat_o,
  input  logic [NARROW_W-1:0]   wbs_dat_i,
  output logic [NARROW_W/8-1:0] wbs_sel_o,
  output logic                  wbs_we_o,
  output logic                  wbs_stb_o,
  output logic                  wbs_cyc_o,
  input  logic                  wbs_ack_i,
  input  logic                  wbs_err_i,
  input  logic                  wbs_rty_i,
  output wb_dsz_state_t         dbg_state
);

  localparam int RATIO = WIDE_W / NARROW_W;
  localparam int WS    = WIDE_W / 8;
  localparam int NS    = NARROW_W / 8;
  localparam int LR    = wb_lane_ratio(WIDE_W, NARROW_W);
  localparam int KW    = (LR > 0) ? LR : 1;
  // Holds counts up to MAX_RETRY+1 (the attempt that gives up).
  localparam int RW    = $clog2(MAX_RETRY + 2);

  wb_dsz_state_t     state_q;
  wb_term_t          term_q;
  logic [ADDR_W-1:0] base_q;
  logic [WIDE_W-1:0] dat_q;
  logic [WS-1:0]     sel_q;
  logic              we_q;
  logic [KW-1:0]     k_q;
  logic [RW-1:0]     retry_q;
  logic [WIDE_W-1:0] rbuf_q;

  // One encoder serves both lookups: the first beat of a new request (from
  // the live sel in IDLE) and the next beat after k (from the latched sel).
  logic [WS-1:0] bs_sel;
  logic [KW:0]   bs_start;
  logic [KW-1:0] bs_idx;
  logic          bs_none;

  always_comb begin
    if (state_q == ST_IDLE) begin
      bs_sel   = wbm_sel_i;
      bs_start = '0;
    end else begin
      bs_sel   = sel_q;
      bs_start = (KW+1)'(k_q) + (KW+1)'(1);
    end
  end

  wb_beat_select #(
    .RATIO (RATIO),
    .NS    (NS),
    .KW    (KW)
  ) u_beat_select (
    .sel       (bs_sel),
    .start     (bs_start),
    .idx       (bs_idx),
    .none_left (bs_none)
  );

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      term_q  <= TERM_ACK;
      base_q  <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      k_q     <= '0;
      retry_q <= '0;
      rbuf_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (wbm_cyc_i && wbm_stb_i) begin
            base_q  <= wbm_adr_i & ~ADDR_W'(WS - 1);
            dat_q   <= wbm_dat_i;
            sel_q   <= wbm_sel_i;
            we_q    <= wbm_we_i;
            rbuf_q  <= '0;
            retry_q <= '0;
            k_q     <= bs_idx;
            term_q  <= TERM_ACK;
            state_q <= bs_none ? ST_RESP : ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (!wbm_cyc_i) begin
            state_q <= ST_IDLE;
          end else if (wbs_err_i) begin
            term_q  <= TERM_ERR;
            state_q <= ST_RESP;
          end else if (wbs_rty_i) begin
            retry_q <= retry_q + RW'(1);
            if (int'(retry_q) < MAX_RETRY) begin
              state_q <= ST_GAP;
            end else begin
              term_q  <= TERM_RTY;
              state_q <= ST_RESP;
            end
          end else if (wbs_ack_i) begin
            if (!we_q) begin
              rbuf_q[k_q*NARROW_W +: NARROW_W] <= wbs_dat_i;
            end
            retry_q <= '0;
            if (bs_none) begin
              term_q  <= TERM_ACK;
              state_q <= ST_RESP;
            end else begin
              k_q <= bs_idx;
            end
          end
        end

        ST_GAP: begin
          state_q <= wbm_cyc_i ? ST_ISSUE : ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  logic busy;
  assign busy = (state_q == ST_ISSUE) || (state_q == ST_GAP);

  // Narrow side is forced to zero outside the burst so stale beat data
  // never appears on the bus while idle or responding.
  assign wbs_cyc_o = busy;
  assign wbs_stb_o = (state_q == ST_ISSUE);
  assign wbs_we_o  = busy & we_q;
  assign wbs_adr_o = busy ? (base_q + ADDR_W'(int'(k_q) * NS)) : '0;
  assign wbs_dat_o = busy ? dat_q[k_q*NARROW_W +: NARROW_W] : '0;
  assign wbs_sel_o = busy ? sel_q[k_q*NS +: NS] : '0;

  assign wbm_ack_o = (state_q == ST_RESP) && (term_q == TERM_ACK);
  assign wbm_err_o = (state_q == ST_RESP) && (term_q == TERM_ERR);
  assign wbm_rty_o = (state_q == ST_RESP) && (term_q == TERM_RTY);
  assign wbm_dat_o = rbuf_q;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_wb_downsizer.sv
module tb_wb_downsizer;
  import wb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- 128 -> 8 DUT ----------------
  logic [13:0]   wbm_adr_i;
  logic [127:0]  wbm_dat_i, wbm_dat_o;
  logic [15:0]   wbm_sel_i;
  logic          wbm_we_i, wbm_stb_i, wbm_cyc_i;
  logic          wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [13:0]   wbs_adr_o;
  logic [7:0]    wbs_dat_o, wbs_dat_i;
  logic [0:0]    wbs_sel_o;
  logic          wbs_we_o, wbs_stb_o, wbs_cyc_o;
  logic          wbs_ack_i, wbs_err_i, wbs_rty_i;
  wb_dsz_state_t dbg_state;

  wb_downsizer #(.WIDE_W(128), .NARROW_W(8), .ADDR_W(14), .MAX_RETRY(3)) u_dut (
    .clk48(clk), .rst_n(rst_n),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_dat_o(wbm_dat_o),
    .wbm_sel_i(wbm_sel_i), .wbm_we_i(wbm_we_i), .wbm_stb_i(wbm_stb_i),
    .wbm_cyc_i(wbm_cyc_i), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbm_rty_o(wbm_rty_o), .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o),
    .wbs_dat_i(wbs_dat_i), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
    .wbs_stb_o(wbs_stb_o), .wbs_cyc_o(wbs_cyc_o), .wbs_ack_i(wbs_ack_i),
    .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i), .dbg_state(dbg_state)
  );

  // ---------------- 128 -> 32 DUT ----------------
  logic [13:0]   m32_adr;
  logic [127:0]  m32_dat_w, m32_dat_r;
  logic [15:0]   m32_sel;
  logic          m32_we, m32_stb, m32_cyc, m32_ack, m32_err, m32_rty;
  logic [13:0]   s32_adr;
  logic [31:0]   s32_dat_w, s32_dat_r;
  logic [3:0]    s32_sel;
  logic          s32_we, s32_stb, s32_cyc;
  wb_dsz_state_t dbg32_state;

  assign s32_dat_r = 32'h0;

  wb_downsizer #(.WIDE_W(128), .NARROW_W(32), .ADDR_W(14), .MAX_RETRY(3)) u_dut32 (
    .clk48(clk), .rst_n(rst_n),
    .wbm_adr_i(m32_adr), .wbm_dat_i(m32_dat_w), .wbm_dat_o(m32_dat_r),
    .wbm_sel_i(m32_sel), .wbm_we_i(m32_we), .wbm_stb_i(m32_stb),
    .wbm_cyc_i(m32_cyc), .wbm_ack_o(m32_ack), .wbm_err_o(m32_err),
    .wbm_rty_o(m32_rty), .wbs_adr_o(s32_adr), .wbs_dat_o(s32_dat_w),
    .wbs_dat_i(s32_dat_r), .wbs_sel_o(s32_sel), .wbs_we_o(s32_we),
    .wbs_stb_o(s32_stb), .wbs_cyc_o(s32_cyc), .wbs_ack_i(s32_stb),
    .wbs_err_i(1'b0), .wbs_rty_i(1'b0), .dbg_state(dbg32_state)
  );

  // ---------------- scripted zero-wait narrow slave ----------------
  // script holds one 2-bit code per stb cycle (0 ack, 1 err, 2 rty);
  // cycles past the script are acked.
  logic [31:0] script_q = 32'h0;
  int          slv_cnt  = 0;
  int          slv_base = 0;
  int          slv_idx;
  logic [1:0]  cur_code;

  always_comb begin
    slv_idx  = slv_cnt - slv_base;
    cur_code = 2'd0;
    if (slv_idx >= 0 && slv_idx < 16) cur_code = script_q[slv_idx*2 +: 2];
  end

  assign wbs_ack_i = wbs_stb_o && (cur_code == 2'd0);
  assign wbs_err_i = wbs_stb_o && (cur_code == 2'd1);
  assign wbs_rty_i = wbs_stb_o && (cur_code == 2'd2);

  always_comb begin
    case (wbs_adr_o)
      14'h0100: wbs_dat_i = 8'hA5;
      14'h0108: wbs_dat_i = 8'h3C;
      default:  wbs_dat_i = 8'h5A;
    endcase
  end

  always @(posedge clk) if (wbs_stb_o) slv_cnt <= slv_cnt + 1;

  // ---------------- monitor ----------------
  typedef struct {
    logic [13:0] adr;
    logic [7:0]  dat;
    logic        sel;
    logic        we;
    logic [1:0]  code;
    int          cyc;
  } beat_t;

  beat_t obs_q[$];
  int    n_gap  = 0;
  int    n_term = 0;

  always @(negedge clk) begin
    beat_t b;
    if (wbs_stb_o) begin
      b.adr = wbs_adr_o; b.dat = wbs_dat_o; b.sel = wbs_sel_o[0];
      b.we = wbs_we_o; b.code = cur_code; b.cyc = cyc_cnt;
      obs_q.push_back(b);
    end
    if (wbs_cyc_o && !wbs_stb_o) n_gap = n_gap + 1;
    if (wbm_ack_o || wbm_err_o || wbm_rty_o) n_term = n_term + 1;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string        name;
    logic [13:0]  adr;
    logic [127:0] dat;
    logic [15:0]  sel;
    logic         we;
    logic [31:0]  script;
    wb_term_t     exp_term;
    int           exp_cyc;
    int           exp_stb;
    int           exp_gap;
    int           exp_beats;
    logic [127:0] exp_rdata;
  } vec_t;

  localparam logic [127:0] PAT = 128'hFFEEDDCC_BBAA9988_77665544_33221100;

  vec_t vecs[8];
  int   t0;

  task automatic drive_idle();
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0;
    wbm_we_i = 1'b0; wbm_stb_i = 1'b0; wbm_cyc_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int       q0, g0, nb, bi, ks[$];
    bit       got;
    wb_term_t term;
    int       term_cyc;
    logic     cyc_at_term;
    logic [127:0] rdata;
    beat_t    beats[$];

    @(negedge clk);
    q0 = obs_q.size(); g0 = n_gap;
    script_q = v.script; slv_base = slv_cnt; t0 = cyc_cnt;
    wbm_adr_i = v.adr; wbm_dat_i = v.dat; wbm_sel_i = v.sel;
    wbm_we_i = v.we; wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;

    got = 0; term = TERM_ACK; term_cyc = -1; cyc_at_term = 1'b1; rdata = '0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (wbm_ack_o || wbm_err_o || wbm_rty_o) begin
        got = 1;
        term = wbm_err_o ? TERM_ERR : (wbm_rty_o ? TERM_RTY : TERM_ACK);
        term_cyc = cyc_cnt - t0;
        cyc_at_term = wbs_cyc_o;
        rdata = wbm_dat_o;
      end
    end
    drive_idle();
    if (!got) begin
      n_checks++; n_err++;
      $display("FAIL %s timeout: no termination within 100 cycles", v.name);
    end else begin
      chk({v.name, " term"},       128'(term),        128'(v.exp_term));
      chk({v.name, " term_cycle"}, 128'(term_cyc),    128'(v.exp_cyc));
      chk({v.name, " cyc_in_resp"}, 128'(cyc_at_term), 128'(0));
      chk({v.name, " rdata"},      rdata,             v.exp_rdata);
    end
    @(negedge clk);
    chk({v.name, " term_pulse"}, {wbm_ack_o, wbm_err_o, wbm_rty_o}, 128'(0));

    chk({v.name, " stb_cycles"}, 128'(obs_q.size() - q0), 128'(v.exp_stb));
    chk({v.name, " gap_cycles"}, 128'(n_gap - g0),        128'(v.exp_gap));
    if (v.exp_stb > 0 && obs_q.size() > q0)
      chk({v.name, " first_stb"}, 128'(obs_q[q0].cyc - t0), 128'(1));

    for (int i = q0; i < obs_q.size(); i++)
      if (obs_q[i].code != 2'd2) beats.push_back(obs_q[i]);
    for (int k = 0; k < 16; k++) if (v.sel[k]) ks.push_back(k);
    nb = beats.size();
    chk({v.name, " beats"}, 128'(nb), 128'(v.exp_beats));
    for (int i = 0; i < nb && i < ks.size(); i++) begin
      bi = ks[i];
      chk($sformatf("%s beat%0d adr", v.name, i), 128'(beats[i].adr),
          128'((v.adr & 14'h3FF0) + 14'(bi)));
      chk($sformatf("%s beat%0d sel", v.name, i), 128'(beats[i].sel), 128'(1));
      chk($sformatf("%s beat%0d we", v.name, i), 128'(beats[i].we), 128'(v.we));
      if (v.we)
        chk($sformatf("%s beat%0d dat", v.name, i), 128'(beats[i].dat), 128'(v.dat[bi*8 +: 8]));
    end
  endtask

  // ---------------- hand-written sequences ----------------
  task automatic seq_32();
    logic [13:0] adr_q[$];
    logic [31:0] dat_q[$];
    logic [3:0]  sel_q[$];
    int          ack_cyc;
    @(negedge clk);
    t0 = cyc_cnt; ack_cyc = -1;
    m32_adr = 14'h0200; m32_dat_w = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    m32_sel = 16'hF0F0; m32_we = 1'b1; m32_cyc = 1'b1; m32_stb = 1'b1;
    for (int n = 0; n < 20 && ack_cyc < 0; n++) begin
      @(negedge clk);
      if (s32_stb) begin
        adr_q.push_back(s32_adr); dat_q.push_back(s32_dat_w); sel_q.push_back(s32_sel);
      end
      if (m32_ack) ack_cyc = cyc_cnt - t0;
    end
    m32_cyc = 1'b0; m32_stb = 1'b0; m32_sel = '0;
    chk("w32 ack_cycle", 128'(ack_cyc), 128'(3));
    chk("w32 beats", 128'(adr_q.size()), 128'(2));
    if (adr_q.size() == 2) begin
      chk("w32 beat0 adr", 128'(adr_q[0]), 128'(14'h0204));
      chk("w32 beat0 dat", 128'(dat_q[0]), 128'(32'h07060504));
      chk("w32 beat0 sel", 128'(sel_q[0]), 128'(4'hF));
      chk("w32 beat1 adr", 128'(adr_q[1]), 128'(14'h020C));
      chk("w32 beat1 dat", 128'(dat_q[1]), 128'(32'h0F0E0D0C));
      chk("w32 beat1 sel", 128'(sel_q[1]), 128'(4'hF));
    end
    @(negedge clk);
  endtask

  task automatic seq_abort();
    int q0, tm0;
    @(negedge clk);
    q0 = obs_q.size(); script_q = 32'h0; slv_base = slv_cnt; t0 = cyc_cnt;
    wbm_adr_i = 14'h0300; wbm_dat_i = PAT; wbm_sel_i = 16'hFFFF;
    wbm_we_i = 1'b1; wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
    while ((cyc_cnt - t0) < 6) @(negedge clk);
    tm0 = n_term;
    chk("abort beat5 stb", 128'(wbs_stb_o), 128'(1));
    chk("abort beat5 adr", 128'(wbs_adr_o), 128'(14'h0305));
    drive_idle();
    @(negedge clk);
    chk("abort cyc_next", {wbs_cyc_o, wbs_stb_o}, 128'(0));
    repeat (4) @(negedge clk);
    chk("abort no_term", 128'(n_term - tm0), 128'(0));
    chk("abort stb_cycles", 128'(obs_q.size() - q0), 128'(6));
  endtask

  task automatic seq_reset();
    @(negedge clk);
    script_q = 32'h0; slv_base = slv_cnt; t0 = cyc_cnt;
    wbm_adr_i = 14'h0000; wbm_dat_i = PAT; wbm_sel_i = 16'hFFFF;
    wbm_we_i = 1'b1; wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
    while ((cyc_cnt - t0) < 4) @(negedge clk);
    chk("rst mid_burst stb", 128'(wbs_stb_o), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("rst async outputs",
        {wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o,
         wbm_ack_o, wbm_err_o, wbm_rty_o}, 128'(0));
    chk("rst async rdata", wbm_dat_o, 128'(0));
    chk("rst async state", 128'(dbg_state), 128'(ST_IDLE));
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0]);
  endtask

  // ---------------- main ----------------
  initial begin
    rst_n = 1'b0;
    drive_idle();
    m32_adr = '0; m32_dat_w = '0; m32_sel = '0; m32_we = 1'b0; m32_stb = 1'b0; m32_cyc = 1'b0;

    //           name        adr      dat   sel      we    script        term      cyc stb gap beats rdata
    vecs[0] = '{"wr_full",   14'h0100, PAT, 16'hFFFF, 1'b1, 32'h0,       TERM_ACK, 17, 16, 0, 16, 128'h0};
    vecs[1] = '{"rd_0101",   14'h0100, '0,  16'h0101, 1'b0, 32'h0,       TERM_ACK, 3,  2,  0, 2,
                128'h00000000_0000003C_00000000_000000A5};
    vecs[2] = '{"wr_nosel",  14'h0100, PAT, 16'h0000, 1'b1, 32'h0,       TERM_ACK, 1,  0,  0, 0,  128'h0};
    vecs[3] = '{"rd_top",    14'h0107, '0,  16'h8000, 1'b0, 32'h0,       TERM_ACK, 2,  1,  0, 1,
                128'h5A000000_00000000_00000000_00000000};
    vecs[4] = '{"rty2",      14'h0100, PAT, 16'h0001, 1'b1, 32'h0000000A, TERM_ACK, 6, 3,  2, 1,  128'h0};
    vecs[5] = '{"rty4",      14'h0100, PAT, 16'hFFFF, 1'b1, 32'h000000AA, TERM_RTY, 8, 4,  3, 0,  128'h0};
    vecs[6] = '{"err3",      14'h0100, PAT, 16'hFFFF, 1'b1, 32'h00000040, TERM_ERR, 5, 4,  0, 4,  128'h0};
    vecs[7] = '{"rty_reset", 14'h0100, PAT, 16'h0003, 1'b1, 32'h00002A2A, TERM_ACK, 15, 8, 6, 2,  128'h0};

    repeat (2) @(negedge clk);
    chk("reset outputs",
        {wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o,
         wbm_ack_o, wbm_err_o, wbm_rty_o}, 128'(0));
    chk("reset rdata", wbm_dat_o, 128'(0));
    chk("reset state", 128'(dbg_state), 128'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);
    seq_32();
    seq_abort();
    seq_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
